// File: rtl/wb_gpio_irq.sv
// Wishbone B3 classic GPIO slave: per-pin direction, atomic set/clear, input
// synchroniser and per-pin edge interrupts collected in a W1C status register.
module wb_gpio_irq #(
    parameter int                WIDTH       = 32,
    parameter int                SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]  RESET_OUT   = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]  RESET_DIR   = {WIDTH{1'b0}}
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    localparam logic [2:0] ADR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADR_DIR      = 3'd2;
    localparam logic [2:0] ADR_OUT_SET  = 3'd3;
    localparam logic [2:0] ADR_OUT_CLR  = 3'd4;
    localparam logic [2:0] ADR_RISE_EN  = 3'd5;
    localparam logic [2:0] ADR_FALL_EN  = 3'd6;
    localparam logic [2:0] ADR_STATUS   = 3'd7;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Zero-extend a pin vector to the bus width; unimplemented bits read 0.
    function automatic logic [31:0] to_bus(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'h0000_0000;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] data_out_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [WIDTH-1:0] status_r;
    logic             irq_r;
    logic             ack_r;
    logic [31:0]      dat_r;

    logic [WIDTH-1:0] sync_out_s;
    logic             access_s;
    logic             wr_s;
    logic [31:0]      lane_mask_s;
    logic [WIDTH-1:0] wmask_s;
    logic [WIDTH-1:0] wdat_s;
    logic [WIDTH-1:0] w1c_s;
    logic [WIDTH-1:0] edge_s;
    logic [31:0]      rd_s;

    assign sync_out_s  = sync_r[SYNC_STAGES-1];
    assign access_s    = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr_s        = access_s & wb_we_i;
    assign lane_mask_s = lane_mask(wb_sel_i);
    assign wmask_s     = lane_mask_s[WIDTH-1:0];
    assign wdat_s      = wb_dat_i[WIDTH-1:0] & wmask_s;
    assign edge_s      = (sync_out_s & ~prev_r & rise_en_r) |
                         (~sync_out_s & prev_r & fall_en_r);

    // W1C mask for the status register, active only on an accepted write.
    always_comb begin
        if (wr_s && (wb_adr_i == ADR_STATUS)) begin
            w1c_s = wdat_s;
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
    end

    // Read data mux; write-only registers read as zero.
    always_comb begin
        rd_s = 32'h0000_0000;
        case (wb_adr_i)
            ADR_DATA_IN:  rd_s = to_bus(sync_out_s);
            ADR_DATA_OUT: rd_s = to_bus(data_out_r);
            ADR_DIR:      rd_s = to_bus(dir_r);
            ADR_RISE_EN:  rd_s = to_bus(rise_en_r);
            ADR_FALL_EN:  rd_s = to_bus(fall_en_r);
            ADR_STATUS:   rd_s = to_bus(status_r);
            default:      rd_s = 32'h0000_0000;
        endcase
    end

    // Bus handshake and writable control registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_r      <= 1'b0;
            dat_r      <= 32'h0000_0000;
            data_out_r <= RESET_OUT;
            dir_r      <= RESET_DIR;
            rise_en_r  <= {WIDTH{1'b0}};
            fall_en_r  <= {WIDTH{1'b0}};
        end else begin
            ack_r <= access_s;
            dat_r <= access_s ? rd_s : 32'h0000_0000;
            if (wr_s) begin
                case (wb_adr_i)
                    ADR_DATA_OUT: data_out_r <= (data_out_r & ~wmask_s) | wdat_s;
                    ADR_DIR:      dir_r      <= (dir_r & ~wmask_s) | wdat_s;
                    ADR_OUT_SET:  data_out_r <= data_out_r | wdat_s;
                    ADR_OUT_CLR:  data_out_r <= data_out_r & ~wdat_s;
                    ADR_RISE_EN:  rise_en_r  <= (rise_en_r & ~wmask_s) | wdat_s;
                    ADR_FALL_EN:  fall_en_r  <= (fall_en_r & ~wmask_s) | wdat_s;
                    default:      ;
                endcase
            end
        end
    end

    // Input synchroniser, edge history, status capture and interrupt.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
            prev_r   <= {WIDTH{1'b0}};
            status_r <= {WIDTH{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            sync_r[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r   <= sync_out_s;
            // A fresh edge overrides a same-cycle clear on that bit.
            status_r <= (status_r & ~w1c_s) | edge_s;
            irq_r    <= |status_r;
        end
    end

    assign wb_ack_o   = ack_r;
    assign wb_dat_o   = dat_r;
    assign wb_err_o   = 1'b0;
    assign gpio_o     = data_out_r;
    assign gpio_dir_o = dir_r;
    assign irq_o      = irq_r;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Randomised and directed bench for wb_gpio_irq (WIDTH=8, RESET_DIR=8'h0F)
// against a cycle-level behavioural model of the register map.
module tb_wb_gpio_irq;

    localparam int W = 8;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  adr = 3'd0;
    logic [31:0] wdat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_dir;
    logic        irq;

    wb_gpio_irq #(.WIDTH(W), .SYNC_STAGES(S), .RESET_OUT(8'h00), .RESET_DIR(8'h0F)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err),
        .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_dir_o(gpio_dir), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_status;
    logic         m_irq, m_ack, m_rd;
    logic [31:0]  m_dat;
    logic [W-1:0] samp [S+1];   // samp[0] = pin value taken at the most recent edge

    task automatic model_reset();
        m_out = 8'h00; m_dir = 8'h0F; m_rise = '0; m_fall = '0; m_status = '0;
        m_irq = 1'b0; m_ack = 1'b0; m_rd = 1'b0; m_dat = 32'h0;
        for (int k = 0; k <= S; k++) samp[k] = '0;
    endtask

    // Advance one clock: predict from the inputs presented, then compare.
    task automatic cycle();
        logic [W-1:0] din, prv, m, d, ev, clr;
        logic [W-1:0] n_out, n_dir, n_rise, n_fall;
        logic         acc, n_irq;
        din = samp[S-1];
        prv = samp[S];
        m = {{2{sel[0]}}, {2{sel[0]}}, {4{sel[0]}}};
        d = wdat[W-1:0] & m;
        n_out = m_out; n_dir = m_dir; n_rise = m_rise; n_fall = m_fall;
        clr = '0;
        acc = cyc && stb && !m_ack;
        n_irq = (m_status != '0);
        if (acc) begin
            m_rd = !we;
            case (adr)
                3'd0: m_dat = {24'h0, din};
                3'd1: m_dat = {24'h0, m_out};
                3'd2: m_dat = {24'h0, m_dir};
                3'd5: m_dat = {24'h0, m_rise};
                3'd6: m_dat = {24'h0, m_fall};
                3'd7: m_dat = {24'h0, m_status};
                default: m_dat = 32'h0;
            endcase
            if (we) begin
                case (adr)
                    3'd1: n_out = (m_out & ~m) | d;
                    3'd2: n_dir = (m_dir & ~m) | d;
                    3'd3: n_out = m_out | d;
                    3'd4: n_out = m_out & ~d;
                    3'd5: n_rise = (m_rise & ~m) | d;
                    3'd6: n_fall = (m_fall & ~m) | d;
                    3'd7: clr = d;
                    default: ;
                endcase
            end
        end
        ev = '0;
        for (int n = 0; n < W; n++) begin
            if (m_rise[n] && din[n] && !prv[n]) ev[n] = 1'b1;
            if (m_fall[n] && !din[n] && prv[n]) ev[n] = 1'b1;
        end
        for (int k = S; k > 0; k--) samp[k] = samp[k-1];
        samp[0] = gpio_in;
        @(posedge clk);
        #1;
        m_status = (m_status & ~clr) | ev;
        m_out = n_out; m_dir = n_dir; m_rise = n_rise; m_fall = n_fall;
        m_irq = n_irq; m_ack = acc;
        chk("ack", {31'h0, ack}, {31'h0, m_ack});
        if (m_ack && m_rd) chk("rdata", rdat, m_dat);
        chk("gpio_o", {24'h0, gpio_out}, {24'h0, m_out});
        chk("gpio_dir", {24'h0, gpio_dir}, {24'h0, m_dir});
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
        chk("err", {31'h0, err}, 32'h0);
    endtask

    task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] dv,
                       input logic [3:0] s, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = dv; sel = s;
        cycle();
        rd = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cycle();
    endtask

    logic [31:0] rv;
    int acks;

    initial begin
        model_reset();
        #22;
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_gpio_o", {24'h0, gpio_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_dat", rdat, 32'h0);
        #3 rst_n = 1'b1;
        cycle();

        bus(1'b0, 3'd2, 32'h0, 4'hF, rv);
        chk("dir_read", rv, 32'h0000_000F);

        bus(1'b1, 3'd1, 32'hFFFF_FF5A, 4'b0001, rv);
        chk("out_5a", {24'h0, gpio_out}, 32'h5A);
        bus(1'b0, 3'd1, 32'h0, 4'hF, rv);
        chk("out_read", rv, 32'h0000_005A);
        bus(1'b1, 3'd1, 32'h0000_00FF, 4'b1110, rv);
        chk("out_sel_off", {24'h0, gpio_out}, 32'h5A);

        bus(1'b1, 3'd3, 32'h0000_0081, 4'hF, rv);
        chk("out_set", {24'h0, gpio_out}, 32'hDB);
        bus(1'b1, 3'd4, 32'h0000_0018, 4'hF, rv);
        chk("out_clr", {24'h0, gpio_out}, 32'hC3);
        bus(1'b0, 3'd3, 32'h0, 4'hF, rv);
        chk("wo_read0", rv, 32'h0);

        bus(1'b1, 3'd5, 32'h0000_0001, 4'hF, rv);
        gpio_in[0] = 1'b1;
        cycle(); cycle(); cycle();
        chk("irq_lat3", {31'h0, irq}, 32'h0);
        cycle();
        chk("irq_lat4", {31'h0, irq}, 32'h1);
        bus(1'b0, 3'd7, 32'h0, 4'hF, rv);
        chk("status_b0", rv, 32'h1);
        bus(1'b1, 3'd7, 32'h0000_0001, 4'hF, rv);
        chk("irq_w1c", {31'h0, irq}, 32'h0);

        bus(1'b1, 3'd6, 32'h0000_0008, 4'hF, rv);
        gpio_in[3] = 1'b1;
        repeat (4) cycle();
        gpio_in[3] = 1'b0;
        repeat (S) cycle();
        bus(1'b1, 3'd7, 32'h0000_0008, 4'b0001, rv);
        bus(1'b0, 3'd7, 32'h0, 4'hF, rv);
        chk("set_wins", rv, 32'h0000_0008);
        bus(1'b1, 3'd7, 32'h0000_0008, 4'b0001, rv);
        bus(1'b0, 3'd7, 32'h0, 4'hF, rv);
        chk("status_clr", rv, 32'h0);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd0; sel = 4'hF;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (ack) acks++;
        end
        chk("acks10", acks, 5);
        cycle();
        chk("ack_before_rst", {31'h0, ack}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("ack_rst_async", {31'h0, ack}, 32'h0);
        chk("dir_rst_async", {24'h0, gpio_dir}, 32'h0F);
        cyc = 1'b0; stb = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        cycle();

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) cycle();
            end else begin
                bus(1'($urandom), 3'($urandom), $urandom, 4'($urandom), rv);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
